dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter that shares the single data memory (9-bit address, 16-bit data, one read/write strobe) between the CPU data port (port A) and a debug/loader port (port B). It sits between the CPU and the data memory in the top level, replacing the direct CPU-to-memory connection. Each port sees a req/ack handshake. The arbiter serialises accesses with a three-state FSM and round-robin fairness, and blocks port-B writes to a protected address window.

## Interface
Parameters:
- AW, 9: address width.
- DW, 16: data width.
- PROTECT_BASE, 9'h1F0: port-B writes to addresses >= this value are blocked (memory-mapped I/O region).

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- a_req  input  1  port A request; held with a_we/a_addr/a_wdata stable until a_ack.
- a_we  input  1  1 = write, 0 = read.
- a_addr  input  AW  port A address.
- a_wdata  input  DW  port A write data.
- a_ack  output  1  one-cycle completion pulse.
- a_rdata  output  DW  registered read data, valid in the a_ack cycle and held until the next port-A read.
- b_req, b_we, b_addr, b_wdata, b_ack, b_rdata: same as port A, for port B.
- b_err  output  1  one-cycle pulse with b_ack when a port-B write was blocked.
- mem_rw  output  1  memory write strobe (1 = write), asserted only in ACCESS.
- mem_addr  output  AW  memory address.
- mem_wdata  output  DW  memory write data.
- mem_rdata  input  DW  memory read data, combinational from mem_addr.
- busy  output  1  high whenever state != IDLE.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- **IDLE**
  - No req: stay in IDLE.
  - Exactly one req high: grant that port and go to ACCESS.
  - Both high: grant the port not served last (`last` register), then go to ACCESS.
  - On grant, latch owner, we, addr and wdata from the granted port into internal registers.
- **ACCESS** (exactly 1 cycle)
  - Drive mem_addr and mem_wdata from the latched registers.
  - mem_rw = latched we, except 0 when owner = B, we = 1 and addr >= PROTECT_BASE (blocked write).
  - Read: capture mem_rdata into the owner's rdata register at the end of the cycle.
  - Update `last` to owner.
  - Go to DONE.
- **DONE** (exactly 1 cycle)
  - Pulse the owner's ack.
  - Pulse b_err if the write was blocked.
  - Go to IDLE.
- Requester req in the DONE cycle is ignored. A req still high in IDLE starts a new transaction, so a requester must drop req in or after its ack cycle to avoid a repeat access.
- Outputs while not in ACCESS: mem_rw = 0; mem_addr and mem_wdata hold their last values (no toggling).
- Non-owner rdata is never modified.
- Protection applies to port B only. Port A (CPU) may write anywhere. Port-B reads of the protected window are allowed.
- Address and data pass through unchanged; no width conversion.

## Timing
- Reset (async assert, sync release):
  - state = IDLE, last = B (port A wins the first tie), owner = A.
  - All acks, b_err, mem_rw and busy = 0.
  - a_rdata, b_rdata, mem_addr and mem_wdata = 0.
- Latency, req high in IDLE (cycle 0) to ack: ACCESS in cycle 1, ack in cycle 2. Memory write commits at the cycle-1 rising edge boundary.
- Throughput: one access per 3 cycles. With both ports continuously requesting, grants alternate A, B, A, B.
- A req raised during ACCESS or DONE by the other port is served at the next IDLE.
- Reset asserted mid-transaction:
  - The FSM aborts immediately; no ack is issued.
  - An in-progress write may or may not have committed; requesters re-issue after reset.
- busy is registered and equals (state != IDLE).

## Test plan
- Single port-A write, then read: a_req, a_we = 1, addr 9'h010, data 16'hBEEF. Required: mem_rw = 1 in cycle 1 only and a_ack in cycle 2. A following read of 9'h010 returns a_rdata = 16'hBEEF in its ack cycle.
- Simultaneous first request: a_req and b_req rise together after reset. Required: A is granted first (a_ack at cycle 2) and B second (b_ack at cycle 5).
- Continuous contention: both req held high for 12 cycles with reads. Required: acks alternate A, B, A, B at cycles 2, 5, 8, 11.
- Protected write: b_we = 1, b_addr = 9'h1F4, data 16'h1234. Required: mem_rw stays 0, b_ack and b_err pulse together, and memory is unchanged. The same write from port A asserts mem_rw.
- Reset mid-ACCESS: assert rst_n = 0 during cycle 1 of a port-B read. Required: state = IDLE, no b_ack, all outputs at reset values, and b_rdata = 0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Shares the single data memory between the CPU data port (A) and the debug/loader
// port (B). Accesses are serialised round-robin, and port-B writes into the I/O window are blocked.
module dmem_arbiter #(
  parameter int              AW           = 9,
  parameter int              DW           = 16,
  parameter logic [AW-1:0]   PROTECT_BASE = 9'h1F0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_ack,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_ack,
  output logic [DW-1:0] b_rdata,
  output logic          b_err,
  output logic          mem_rw,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t        state;
  state_t        next_state;
  logic          last_b;
  logic          owner_b;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          busy_q;
  logic          grant_b;
  logic          blocked;

  // On a tie, B wins only if A was served last.
  assign grant_b  = b_req && (!a_req || !last_b);
  assign blocked  = owner_b && we_q && (addr_q >= PROTECT_BASE);

  // The latched address/data only change at a grant, so the memory bus stays quiet outside ACCESS.
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy_q <= 1'b0;
    end else begin
      state  <= next_state;
      busy_q <= (next_state != IDLE);
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (a_req || b_req) next_state = ACCESS;
      ACCESS:  next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    mem_rw = 1'b0;
    a_ack  = 1'b0;
    b_ack  = 1'b0;
    b_err  = 1'b0;
    case (state)
      ACCESS: mem_rw = we_q && !blocked;
      DONE: begin
        a_ack = !owner_b;
        b_ack = owner_b;
        b_err = blocked;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_b  <= 1'b1;
      owner_b <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      a_rdata <= '0;
      b_rdata <= '0;
    end else begin
      if (state == IDLE && (a_req || b_req)) begin
        owner_b <= grant_b;
        we_q    <= grant_b ? b_we    : a_we;
        addr_q  <= grant_b ? b_addr  : a_addr;
        wdata_q <= grant_b ? b_wdata : a_wdata;
      end
      if (state == ACCESS) begin
        last_b <= owner_b;
        if (!we_q) begin
          if (owner_b) b_rdata <= mem_rdata;
          else         a_rdata <= mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a transaction-level model plus a memory array, checked every cycle,
// with directed scenarios pinning the model and a randomized two-requester phase.
module tb_dmem_arbiter;
  localparam int AW = 9;
  localparam int DW = 16;
  localparam logic [AW-1:0] PB = 9'h1F0;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          a_req, a_we, b_req, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic          a_ack, b_ack, b_err, mem_rw, busy;
  logic [DW-1:0] a_rdata, b_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  logic [DW-1:0] mem     [0:511];
  logic [DW-1:0] ref_mem [0:511];

  // Model: at most one transaction in flight, aged 1 (memory cycle) then 2 (ack cycle).
  bit            m_active, m_owner_b, m_we, m_blocked, m_last_b;
  int            m_age;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_a_rdata, m_b_rdata;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  dmem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata), .b_err(b_err),
    .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_rw) mem[mem_addr] <= mem_wdata;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endfunction

  function automatic void model_reset();
    m_active = 0; m_age = 0; m_owner_b = 0; m_we = 0; m_blocked = 0;
    m_addr = '0; m_wdata = '0; m_a_rdata = '0; m_b_rdata = '0; m_last_b = 1;
  endfunction

  function automatic bit exp_a_ack();
    return m_active && m_age == 2 && !m_owner_b;
  endfunction

  function automatic bit exp_b_ack();
    return m_active && m_age == 2 && m_owner_b;
  endfunction

  // Advances the model across the coming rising edge using the inputs now applied.
  function automatic void model_update();
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (m_active) begin
      if (m_age == 1) begin
        if (m_we && !m_blocked) ref_mem[m_addr] = m_wdata;
        else if (!m_we) begin
          if (m_owner_b) m_b_rdata = ref_mem[m_addr];
          else           m_a_rdata = ref_mem[m_addr];
        end
        m_last_b = m_owner_b;
        m_age = 2;
      end else begin
        m_active = 0;
        m_age = 0;
      end
    end else if (a_req || b_req) begin
      m_owner_b = b_req && (!a_req || !m_last_b);
      m_we      = m_owner_b ? b_we    : a_we;
      m_addr    = m_owner_b ? b_addr  : a_addr;
      m_wdata   = m_owner_b ? b_wdata : a_wdata;
      m_blocked = m_owner_b && m_we && (m_addr >= PB);
      m_active  = 1;
      m_age     = 1;
    end
  endfunction

  function automatic void check_output();
    check("busy",      busy,      m_active);
    check("mem_rw",    mem_rw,    m_active && m_age == 1 && m_we && !m_blocked);
    check("mem_addr",  mem_addr,  m_addr);
    check("mem_wdata", mem_wdata, m_wdata);
    check("a_ack",     a_ack,     exp_a_ack());
    check("b_ack",     b_ack,     exp_b_ack());
    check("b_err",     b_err,     exp_b_ack() && m_blocked);
    check("a_rdata",   a_rdata,   m_a_rdata);
    check("b_rdata",   b_rdata,   m_b_rdata);
  endfunction

  task automatic tick();
    model_update();
    @(negedge clk);
    cyc++;
    check_output();
  endtask

  task automatic do_reset();
    rst_n = 0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1;
    cyc = 0;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return AW'(32'h1F0 + $urandom_range(0, 15));
    return AW'($urandom_range(0, 15));
  endfunction

  // Each requester holds its request until its ack, drops it, then may re-request later.
  task automatic apply_stimulus();
    if (a_req) begin
      if (exp_a_ack()) a_req = 0;
    end else if ($urandom_range(0, 2) == 0) begin
      a_req = 1; a_we = 1'($urandom_range(0, 1)); a_addr = rand_addr(); a_wdata = DW'($urandom);
    end
    if (b_req) begin
      if (exp_b_ack()) b_req = 0;
    end else if ($urandom_range(0, 2) == 0) begin
      b_req = 1; b_we = 1'($urandom_range(0, 1)); b_addr = rand_addr(); b_wdata = DW'($urandom);
    end
  endtask

  initial begin
    int a_cyc, b_cyc;
    logic [31:0] a_mask, b_mask;
    for (int i = 0; i < 512; i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end
    a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
    rst_n = 0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1;
    check_output();
    check("rst_busy", busy, 0);
    check("rst_a_rdata", a_rdata, 0);
    check("rst_mem_addr", mem_addr, 0);

    // Port-A write then read back
    a_req = 1; a_we = 1; a_addr = 9'h010; a_wdata = 16'hBEEF;
    tick(); check("t1_rw_c1", mem_rw, 1);
    tick(); check("t1_ack_c2", a_ack, 1); check("t1_rw_c2", mem_rw, 0);
    a_req = 0;
    tick();
    a_req = 1; a_we = 0;
    tick(); tick();
    check("t1_rd_ack", a_ack, 1); check("t1_rdata", a_rdata, 16'hBEEF);
    a_req = 0;
    tick();

    // Simultaneous first request after reset: A first, then B
    do_reset();
    a_req = 1; a_we = 0; a_addr = 9'h011;
    b_req = 1; b_we = 0; b_addr = 9'h012;
    a_cyc = -1; b_cyc = -1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (a_ack && a_cyc < 0) a_cyc = k;
      if (b_ack && b_cyc < 0) b_cyc = k;
      if (exp_a_ack()) a_req = 0;
      if (exp_b_ack()) b_req = 0;
    end
    check("t2_a_ack_cycle", a_cyc, 2);
    check("t2_b_ack_cycle", b_cyc, 5);

    // Continuous contention: acks alternate A,B,A,B at 2,5,8,11
    do_reset();
    a_req = 1; a_we = 0; a_addr = 9'h010;
    b_req = 1; b_we = 0; b_addr = 9'h013;
    a_mask = 0; b_mask = 0;
    for (int k = 1; k <= 11; k++) begin
      tick();
      if (a_ack) a_mask |= (32'd1 << k);
      if (b_ack) b_mask |= (32'd1 << k);
    end
    a_req = 0; b_req = 0;
    check("t3_a_ack_mask", a_mask, 32'h104);
    check("t3_b_ack_mask", b_mask, 32'h820);
    repeat (2) tick();

    // Blocked port-B write into the protected window, then the same write from A
    b_req = 1; b_we = 1; b_addr = 9'h1F4; b_wdata = 16'h1234;
    tick(); check("t4_b_rw", mem_rw, 0);
    tick(); check("t4_b_ack", b_ack, 1); check("t4_b_err", b_err, 1);
    b_req = 0;
    tick(); check("t4_mem_kept", mem[9'h1F4], 16'h0000);
    a_req = 1; a_we = 1; a_addr = 9'h1F4; a_wdata = 16'h1234;
    tick(); check("t4_a_rw", mem_rw, 1);
    tick(); check("t4_a_ack", a_ack, 1); check("t4_a_no_err", b_err, 0);
    a_req = 0;
    tick(); check("t4_mem_written", mem[9'h1F4], 16'h1234);

    // Reset during the memory cycle of a port-B read
    b_req = 1; b_we = 0; b_addr = 9'h010;
    tick(); check("t5_in_access", busy, 1);
    rst_n = 0;
    model_reset();
    b_req = 0;
    #1;
    check("t5_busy", busy, 0);
    check("t5_b_ack", b_ack, 0);
    check("t5_mem_rw", mem_rw, 0);
    check("t5_mem_addr", mem_addr, 0);
    check("t5_mem_wdata", mem_wdata, 0);
    check("t5_a_rdata", a_rdata, 0);
    check("t5_b_rdata", b_rdata, 0);
    @(negedge clk);
    check_output();
    check("t5_b_ack_later", b_ack, 0);
    rst_n = 1;

    // Randomized traffic from both requesters
    for (int k = 0; k < 1500; k++) begin
      apply_stimulus();
      tick();
    end
    a_req = 0; b_req = 0;
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
